// File: rtl/router_pkg.sv
// Shared definitions for the router control path: FSM state encoding and port addresses.
// Optional ROUTER_FSM_DROP_INVALID_EN adds DROP_PACKET, which needs a fourth state bit.
// No logic here; definitions only.
package router_pkg;

  // Destination address field values carried in the header byte
  localparam logic [1:0] PORT_0       = 2'd0;
  localparam logic [1:0] PORT_1       = 2'd1;
  localparam logic [1:0] PORT_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

`ifdef ROUTER_FSM_DROP_INVALID_EN
  // Nine states do not fit in three bits; unused codes 9..15 fall back to decode.
  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_e;
`else
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;
`endif

  // Pick the per-port flag addressed by addr; the invalid address selects nothing.
  function automatic logic port_sel(input logic [1:0] addr, input logic [2:0] flags);
    logic sel;
    case (addr)
      PORT_0:  sel = flags[0];
      PORT_1:  sel = flags[1];
      PORT_2:  sel = flags[2];
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences FIFO loads, parity and full stalls.
// Latency: Moore outputs decoded straight from the state register (zero cycles after a state change).
// Backpressure: fifo_full parks the FSM in FIFO_FULL_STATE; a busy target FIFO parks it in WAIT_TILL_EMPTY.
// Build option: define ROUTER_FSM_DROP_INVALID_EN to swallow packets addressed to port 3.
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_en_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] target_q, target_d;

  logic [2:0] empty_vec;
  logic [2:0] soft_rst_vec;
  logic       addr_ok;
  logic       empty_addr;
  logic       empty_tgt;
  logic       soft_rst_tgt;

  assign empty_vec    = {empty_2, empty_1, empty_0};
  assign soft_rst_vec = {soft_rst_2, soft_rst_1, soft_rst_0};
  assign addr_ok      = (data_in != ADDR_INVALID);
  // The header decision looks at the live address; later stages look at the latched target.
  assign empty_addr   = port_sel(data_in, empty_vec);
  assign empty_tgt    = port_sel(target_q, empty_vec);
  assign soft_rst_tgt = port_sel(target_q, soft_rst_vec);

  // Next-state and target-latch logic; a soft reset of the target port overrides everything.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;

    if (state_q == DECODE_ADDRESS && pkt_valid) begin
      target_d = data_in;
    end

    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (addr_ok) begin
            state_d = empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
`ifdef ROUTER_FSM_DROP_INVALID_EN
          else begin
            state_d = DROP_PACKET;
          end
`endif
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_tgt) begin
          state_d = LOAD_FIRST_DATA;
        end
      end
`ifdef ROUTER_FSM_DROP_INVALID_EN
      DROP_PACKET: begin
        if (!pkt_valid) begin
          state_d = DECODE_ADDRESS;
        end
      end
`endif
      default: state_d = DECODE_ADDRESS;
    endcase

    if (state_q != DECODE_ADDRESS && soft_rst_tgt) begin
      state_d = DECODE_ADDRESS;
    end
  end

  // State and target registers; reset returns to address decode with target port 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= DECODE_ADDRESS;
      target_q <= PORT_0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Moore output decode
  assign detect_addr  = (state_q == DECODE_ADDRESS);
  assign lfd_state    = (state_q == LOAD_FIRST_DATA);
  assign ld_state     = (state_q == LOAD_DATA);
  assign full_state   = (state_q == FIFO_FULL_STATE);
  assign laf_state    = (state_q == LOAD_AFTER_FULL);
  assign rst_int_reg  = (state_q == CHECK_PARITY_ERROR);
  assign write_en_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == LOAD_AFTER_FULL);
`ifdef ROUTER_FSM_DROP_INVALID_EN
  assign busy = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA) ||
                  (state_q == DROP_PACKET));
`else
  assign busy = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: per-cycle stimulus with expected output vectors.
// Expected vectors are pushed to a scoreboard when a cycle is driven and popped after the edge.
// Honours ROUTER_FSM_DROP_INVALID_EN for the invalid-address scenario.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       empty_0, empty_1, empty_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
  logic       write_en_reg, rst_int_reg, busy;

  // Output vector: {detect, lfd, ld, laf, full, write_en, rst_int, busy}
  logic [7:0] outs;
  assign outs = {detect_addr, lfd_state, ld_state, laf_state, full_state,
                 write_en_reg, rst_int_reg, busy};

  localparam logic [7:0] S_DA   = 8'b1000_0000;
  localparam logic [7:0] S_LFD  = 8'b0100_0001;
  localparam logic [7:0] S_LD   = 8'b0010_0100;
  localparam logic [7:0] S_LAF  = 8'b0001_0101;
  localparam logic [7:0] S_FULL = 8'b0000_1001;
  localparam logic [7:0] S_LP   = 8'b0000_0101;
  localparam logic [7:0] S_CPE  = 8'b0000_0011;
  localparam logic [7:0] S_WTE  = 8'b0000_0001;
  localparam logic [7:0] S_DROP = 8'b0000_0000;

  typedef struct {
    logic       pv;
    logic [1:0] di;
    logic       ff;
    logic [2:0] em;
    logic [2:0] sr;
    logic       pd;
    logic       lp;
    logic [7:0] exp;
  } stim_t;

  stim_t      stim_q[$];
  logic [7:0] sb_q[$];
  stim_t      s;
  logic [7:0] exp_v;
  int         total = 0;
  int         bad   = 0;

  router_fsm dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1), .soft_rst_2(soft_rst_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_en_reg(write_en_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic pv, input logic [1:0] di, input logic ff,
                     input logic [2:0] em, input logic [2:0] sr,
                     input logic pd, input logic lp, input logic [7:0] exp);
    stim_t t;
    t.pv = pv; t.di = di; t.ff = ff; t.em = em; t.sr = sr;
    t.pd = pd; t.lp = lp; t.exp = exp;
    stim_q.push_back(t);
  endtask

  task automatic drive(input stim_t t);
    pkt_valid     = t.pv;
    data_in       = t.di;
    fifo_full     = t.ff;
    {empty_2, empty_1, empty_0}          = t.em;
    {soft_rst_2, soft_rst_1, soft_rst_0} = t.sr;
    parity_done   = t.pd;
    low_pkt_valid = t.lp;
    sb_q.push_back(t.exp);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, S_DA});
    repeat (2) @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    total++;
    if (outs !== exp_v) begin
      bad++; $display("FAIL reset_held: outputs=%b expected=%b", outs, exp_v);
    end
    rstn = 1'b1;
    drive('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, S_DA});
    @(posedge clk); #1;
    exp_v = sb_q.pop_front();
    total++;
    if (outs !== exp_v) begin
      bad++; $display("FAIL reset_release: outputs=%b expected=%b", outs, exp_v);
    end
  endtask

  task automatic test_normal();
    add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LFD);
    repeat (3) add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LD);
    add(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LP);
    add(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_CPE);
    add(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_DA);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); drive(s);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); total++;
      if (outs !== exp_v) begin
        bad++; $display("FAIL normal step %0d: outputs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_wait_empty();
    repeat (5) add(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, S_WTE);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LFD);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LD);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LP);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_CPE);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_DA);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); drive(s);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); total++;
      if (outs !== exp_v) begin
        bad++; $display("FAIL wait_empty step %0d: outputs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_fifo_full();
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD);
    repeat (3) add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); drive(s);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); total++;
      if (outs !== exp_v) begin
        bad++; $display("FAIL fifo_full step %0d: outputs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  // LOAD_AFTER_FULL exits via low_pkt_valid and parity_done; CHECK_PARITY_ERROR stalls on full
  task automatic test_laf_branches();
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD);
    add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, S_LAF);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, S_LP);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE);
    add(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF);
    add(0, 2'd0, 0, 3'b111, 3'b000, 1, 0, S_DA);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); drive(s);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); total++;
      if (outs !== exp_v) begin
        bad++; $display("FAIL laf_branches step %0d: outputs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  // Only the latched target's soft reset may abort; other ports' soft resets are ignored
  task automatic test_soft_rst();
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD);
    add(1, 2'd0, 0, 3'b111, 3'b010, 0, 0, S_LD);
    add(1, 2'd0, 0, 3'b111, 3'b001, 0, 0, S_DA);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA);
    add(1, 2'd1, 0, 3'b101, 3'b000, 0, 0, S_WTE);
    add(0, 2'd1, 0, 3'b101, 3'b100, 0, 0, S_WTE);
    add(0, 2'd0, 0, 3'b101, 3'b001, 0, 0, S_WTE);
    add(0, 2'd0, 0, 3'b101, 3'b010, 0, 0, S_DA);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); drive(s);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); total++;
      if (outs !== exp_v) begin
        bad++; $display("FAIL soft_rst step %0d: outputs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_invalid_addr();
`ifdef ROUTER_FSM_DROP_INVALID_EN
    repeat (3) add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_DROP);
`else
    repeat (3) add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_DA);
`endif
    add(0, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_DA);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LFD);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LD);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LP);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_CPE);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_DA);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); drive(s);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); total++;
      if (outs !== exp_v) begin
        bad++; $display("FAIL invalid_addr step %0d: outputs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  // Reset mid-packet acts without a clock edge and abandons the packet
  task automatic test_reset_mid_packet();
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA);
    for (int i = 0; i < 2; i++) begin
      s = stim_q.pop_front(); drive(s);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); total++;
      if (outs !== exp_v) begin
        bad++; $display("FAIL mid_reset step %0d: outputs=%b expected=%b", i, outs, exp_v);
      end
    end
    #2;
    s = stim_q.pop_front(); drive(s);
    rstn = 1'b0;
    #1;
    exp_v = sb_q.pop_front(); total++;
    if (outs !== exp_v) begin
      bad++; $display("FAIL async_reset: outputs=%b expected=%b", outs, exp_v);
    end
    s = stim_q.pop_front(); drive(s);
    @(posedge clk); #1;
    exp_v = sb_q.pop_front(); total++;
    if (outs !== exp_v) begin
      bad++; $display("FAIL reset_hold_pkt: outputs=%b expected=%b", outs, exp_v);
    end
    s = stim_q.pop_front(); drive(s);
    rstn = 1'b1;
    @(posedge clk); #1;
    exp_v = sb_q.pop_front(); total++;
    if (outs !== exp_v) begin
      bad++; $display("FAIL reset_abandon: outputs=%b expected=%b", outs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_wait_empty();
    test_fifo_full();
    test_laf_branches();
    test_soft_rst();
    test_invalid_addr();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
